// File: rtl/gpr_seq_pkg.sv
// Shared encodings for the GPR access sequencer: op/select codes, state encoding, latched command.
package gpr_seq_pkg;

  localparam int unsigned OP_W  = 2;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned ST_W  = 3;

  localparam logic [OP_W-1:0] OP_WRITE = 2'b00;
  localparam logic [OP_W-1:0] OP_READ  = 2'b01;
  localparam logic [OP_W-1:0] OP_MOVE  = 2'b10;

  localparam logic [SEL_W-1:0] SEL_X   = 2'b00;
  localparam logic [SEL_W-1:0] SEL_Y   = 2'b01;
  localparam logic [SEL_W-1:0] SEL_ACC = 2'b10;
  localparam logic [SEL_W-1:0] SEL_INV = 2'b11;

  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_WR    = 3'd1;
  localparam logic [ST_W-1:0] ST_RD    = 3'd2;
  localparam logic [ST_W-1:0] ST_MV_RD = 3'd3;
  localparam logic [ST_W-1:0] ST_MV_WR = 3'd4;
  localparam logic [ST_W-1:0] ST_RESP  = 3'd5;

  typedef enum logic [ST_W-1:0] {
    S_IDLE  = ST_IDLE,
    S_WR    = ST_WR,
    S_RD    = ST_RD,
    S_MV_RD = ST_MV_RD,
    S_MV_WR = ST_MV_WR,
    S_RESP  = ST_RESP
  } state_e;

  // Command fields captured on the accept edge
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [SEL_W-1:0] dst;
    logic [SEL_W-1:0] src;
    logic             err;
  } cmd_t;

endpackage

// File: rtl/gpr_access_sequencer_if.sv
// Command/response handshake plus GPR bank strobe bus for gpr_access_sequencer.
// ops_done exists only when GPR_SEQ_OPCOUNT_EN is defined.
interface gpr_access_sequencer_if #(
  parameter int unsigned DATA_W = 16
`ifdef GPR_SEQ_OPCOUNT_EN
  , parameter int unsigned CNT_W = 16
`endif
);
  import gpr_seq_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [SEL_W-1:0]  cmd_dst;
  logic [SEL_W-1:0]  cmd_src;
  logic [DATA_W-1:0] cmd_data;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  logic [DATA_W-1:0] gpr_data_in;
  logic              gpr_wr_x;
  logic              gpr_wr_y;
  logic              gpr_wr_acc;
  logic              gpr_rd_x;
  logic              gpr_rd_y;
  logic              gpr_rd_acc;
  logic [DATA_W-1:0] gpr_data_out;
  logic [DATA_W-1:0] gpr_data_out_acc;

`ifdef GPR_SEQ_OPCOUNT_EN
  logic [CNT_W-1:0]  ops_done;
`endif

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_data,
    output cmd_ready,
    output rsp_valid, rsp_data, rsp_err,
    input  rsp_ready,
    output gpr_data_in, gpr_wr_x, gpr_wr_y, gpr_wr_acc,
    output gpr_rd_x, gpr_rd_y, gpr_rd_acc,
    input  gpr_data_out, gpr_data_out_acc
`ifdef GPR_SEQ_OPCOUNT_EN
    , output ops_done
`endif
  );

  // Control unit / bank side
  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_data,
    input  cmd_ready,
    input  rsp_valid, rsp_data, rsp_err,
    output rsp_ready,
    input  gpr_data_in, gpr_wr_x, gpr_wr_y, gpr_wr_acc,
    input  gpr_rd_x, gpr_rd_y, gpr_rd_acc,
    output gpr_data_out, gpr_data_out_acc
`ifdef GPR_SEQ_OPCOUNT_EN
    , input ops_done
`endif
  );

endinterface

// File: rtl/gpr_access_sequencer.sv
// Command-driven master for the X/Y/ACC register bank: WRITE/READ/MOVE in, one-hot strobes out.
// Define GPR_SEQ_OPCOUNT_EN to add the wrapping ops_done response counter.
module gpr_access_sequencer
  import gpr_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 16
`ifdef GPR_SEQ_OPCOUNT_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input logic                   clk,
  input logic                   rst,
  gpr_access_sequencer_if.slave bus
);

  // One-hot {acc, y, x}; an invalid select decodes to no strobe
  function automatic logic [2:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [2:0] oh;
    oh = 3'b000;
    case (sel)
      SEL_X:   oh = 3'b001;
      SEL_Y:   oh = 3'b010;
      SEL_ACC: oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] tmp_q, tmp_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [2:0]        wr_q, wr_d;
  logic [2:0]        rd_q, rd_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_fire;
  logic              acc_err;
  logic [DATA_W-1:0] rd_bus;

  // Legality of the incoming command; selects the op does not use are ignored
  always_comb begin
    acc_err = 1'b0;
    case (bus.cmd_op)
      OP_WRITE: acc_err = (bus.cmd_dst == SEL_INV);
      OP_READ:  acc_err = (bus.cmd_src == SEL_INV);
      OP_MOVE:  acc_err = (bus.cmd_dst == SEL_INV) || (bus.cmd_src == SEL_INV);
      default:  acc_err = 1'b1;
    endcase
  end

  assign rd_bus = (cmd_q.src == SEL_ACC) ? bus.gpr_data_out_acc : bus.gpr_data_out;

  // Next state and next registered outputs
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    wdata_d     = wdata_q;
    tmp_d       = tmp_q;
    data_in_d   = data_in_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    wr_d        = 3'b000;
    rd_d        = 3'b000;
    rsp_fire    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          cmd_d   = '{op: bus.cmd_op, dst: bus.cmd_dst, src: bus.cmd_src, err: acc_err};
          wdata_d = bus.cmd_data;
          if (acc_err)                   state_d = S_RESP;
          else if (bus.cmd_op == OP_WRITE) state_d = S_WR;
          else if (bus.cmd_op == OP_READ)  state_d = S_RD;
          else                             state_d = S_MV_RD;
        end
      end
      S_WR: begin
        wr_d      = sel_onehot(cmd_q.dst);
        data_in_d = wdata_q;
        state_d   = S_RESP;
      end
      S_RD: begin
        rd_d    = sel_onehot(cmd_q.src);
        state_d = S_RESP;
      end
      S_MV_RD: begin
        rd_d    = sel_onehot(cmd_q.src);
        state_d = S_MV_WR;
      end
      S_MV_WR: begin
        // Read strobe is live this cycle; forward the bus straight to the write side
        wr_d      = sel_onehot(cmd_q.dst);
        data_in_d = rd_bus;
        tmp_d     = rd_bus;
        state_d   = S_RESP;
      end
      S_RESP: begin
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = cmd_q.err;
          if (cmd_q.err)                  rsp_data_d = '0;
          else if (cmd_q.op == OP_READ)   rsp_data_d = rd_bus;
          else if (cmd_q.op == OP_MOVE)   rsp_data_d = tmp_q;
          else                            rsp_data_d = '0;
        end else if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_data_d  = '0;
          rsp_fire    = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      wdata_q     <= '0;
      tmp_q       <= '0;
      data_in_q   <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      wr_q        <= 3'b000;
      rd_q        <= 3'b000;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      wdata_q     <= wdata_d;
      tmp_q       <= tmp_d;
      data_in_q   <= data_in_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
    end
  end

  assign bus.cmd_ready   = (state_q == S_IDLE);
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.gpr_data_in = data_in_q;
  assign bus.gpr_wr_x    = wr_q[0];
  assign bus.gpr_wr_y    = wr_q[1];
  assign bus.gpr_wr_acc  = wr_q[2];
  assign bus.gpr_rd_x    = rd_q[0];
  assign bus.gpr_rd_y    = rd_q[1];
  assign bus.gpr_rd_acc  = rd_q[2];

`ifdef GPR_SEQ_OPCOUNT_EN
  logic [CNT_W-1:0] ops_q;

  // Completed-response count, errors included, wraps naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          ops_q <= '0;
    else if (rsp_fire) ops_q <= ops_q + CNT_W'(1);
  end

  assign bus.ops_done = ops_q;
`endif

endmodule

// File: tb/tb_gpr_access_sequencer.sv
// Randomized bench for gpr_access_sequencer with a behavioural GPR bank and a transaction-level model.
// Define GPR_SEQ_OPCOUNT_EN to also check ops_done (CNT_W=2 here to exercise wrap).
module tb_gpr_access_sequencer;
  import gpr_seq_pkg::*;

  localparam int unsigned DATA_W = 16;
`ifdef GPR_SEQ_OPCOUNT_EN
  localparam int unsigned CNT_W = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gpr_access_sequencer_if #(
    .DATA_W(DATA_W)
`ifdef GPR_SEQ_OPCOUNT_EN
    , .CNT_W(CNT_W)
`endif
  ) bus ();

  gpr_access_sequencer #(
    .DATA_W(DATA_W)
`ifdef GPR_SEQ_OPCOUNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Peer register bank: captures on write strobe, drives read buses from read strobes
  logic [DATA_W-1:0] bank [3];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank[0] <= '0;
      bank[1] <= '0;
      bank[2] <= '0;
    end else begin
      if (bus.gpr_wr_x)   bank[0] <= bus.gpr_data_in;
      if (bus.gpr_wr_y)   bank[1] <= bus.gpr_data_in;
      if (bus.gpr_wr_acc) bank[2] <= bus.gpr_data_in;
    end
  end
  assign bus.gpr_data_out     = bus.gpr_rd_x ? bank[0] : (bus.gpr_rd_y ? bank[1] : '0);
  assign bus.gpr_data_out_acc = bus.gpr_rd_acc ? bank[2] : '0;

  logic [DATA_W-1:0] mdl [3];
  int unsigned       exp_ops;
  int                n_err;
  int                n_chk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] strobe_of(input logic [1:0] sel);
    return (sel == 2'd3) ? 3'b000 : 3'(32'd1 << sel);
  endfunction

  function automatic logic [2:0] wr_now();
    return {bus.gpr_wr_acc, bus.gpr_wr_y, bus.gpr_wr_x};
  endfunction

  function automatic logic [2:0] rd_now();
    return {bus.gpr_rd_acc, bus.gpr_rd_y, bus.gpr_rd_x};
  endfunction

  task automatic clear_model();
    mdl[0] = '0;
    mdl[1] = '0;
    mdl[2] = '0;
    exp_ops = 0;
  endtask

  // Issue one command from an idle sample point (#1 after an edge) and follow it to completion
  task automatic do_cmd(input logic [1:0] op, input logic [1:0] dst, input logic [1:0] src,
                        input logic [DATA_W-1:0] data, input int dly, input bit early);
    bit                err;
    int                lat;
    int                wr_cyc;
    int                rd_cyc;
    logic [DATA_W-1:0] exp_rsp;
    logic [DATA_W-1:0] exp_wdata;
    logic [2:0]        exp_wr;
    logic [2:0]        exp_rd;

    err       = (op == 2'd3) || (op != 2'd1 && dst == 2'd3) || (op != 2'd0 && src == 2'd3);
    wr_cyc    = -1;
    rd_cyc    = -1;
    exp_rsp   = '0;
    exp_wdata = '0;
    lat       = 1;
    if (!err) begin
      case (op)
        2'd0: begin lat = 2; wr_cyc = 1; exp_wdata = data; mdl[dst] = data; end
        2'd1: begin lat = 2; rd_cyc = 1; exp_rsp = mdl[src]; end
        default: begin
          lat = 3; rd_cyc = 1; wr_cyc = 2;
          exp_rsp = mdl[src]; exp_wdata = mdl[src]; mdl[dst] = mdl[src];
        end
      endcase
    end
    exp_wr = strobe_of(dst);
    exp_rd = strobe_of(src);

    check_eq("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_op    = op;
    bus.cmd_dst   = dst;
    bus.cmd_src   = src;
    bus.cmd_data  = data;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'($urandom);
    bus.cmd_dst   = 2'($urandom);
    bus.cmd_src   = 2'($urandom);
    bus.cmd_data  = DATA_W'($urandom);
    if (early) bus.rsp_ready = 1'b1;

    for (int k = 0; k <= lat + dly + 1; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (k == lat + dly + 1) begin
        check_eq("rsp_drop", 32'(bus.rsp_valid), 32'd0);
        check_eq("cmd_ready_back", 32'(bus.cmd_ready), 32'd1);
        check_eq("wr_after", 32'(wr_now()), 32'd0);
        bus.rsp_ready = 1'b0;
      end else begin
        check_eq("wr_strobe", 32'(wr_now()), 32'((k == wr_cyc) ? exp_wr : 3'b000));
        check_eq("rd_strobe", 32'(rd_now()), 32'((k == rd_cyc) ? exp_rd : 3'b000));
        check_eq("cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
        check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(k >= lat));
        if (k == wr_cyc) check_eq("data_in", 32'(bus.gpr_data_in), 32'(exp_wdata));
        if (k >= lat) begin
          check_eq("rsp_data", 32'(bus.rsp_data), 32'(exp_rsp));
          check_eq("rsp_err", 32'(bus.rsp_err), 32'(err));
        end
        if (k == lat + dly) bus.rsp_ready = 1'b1;
      end
    end
    exp_ops++;
`ifdef GPR_SEQ_OPCOUNT_EN
    check_eq("ops_done", 32'(bus.ops_done), 32'(exp_ops % (32'd1 << CNT_W)));
`endif
  endtask

  // MOVE Y->ACC cut by reset while the ACC write strobe is high
  task automatic reset_mid_move();
    check_eq("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_op    = OP_MOVE;
    bus.cmd_dst   = SEL_ACC;
    bus.cmd_src   = SEL_Y;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("mv_rd_y", 32'(rd_now()), 32'b010);
    @(posedge clk);
    #1;
    check_eq("mv_wr_acc", 32'(wr_now()), 32'b100);
    rst = 1'b0;
    #1;
    check_eq("rst_wr", 32'(wr_now()), 32'd0);
    check_eq("rst_rd", 32'(rd_now()), 32'd0);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    clear_model();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("no_rsp_after_rst", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    int r;
    logic [1:0] op, dst, src;
    int dly;

    n_err = 0;
    n_chk = 0;
    clear_model();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_dst   = '0;
    bus.cmd_src   = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_wr", 32'(wr_now()), 32'd0);
    check_eq("reset_rd", 32'(rd_now()), 32'd0);
    check_eq("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    check_eq("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
    check_eq("reset_data_in", 32'(bus.gpr_data_in), 32'd0);
    check_eq("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
`ifdef GPR_SEQ_OPCOUNT_EN
    check_eq("reset_ops_done", 32'(bus.ops_done), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    do_cmd(OP_WRITE, SEL_X, SEL_INV, 16'hA5A5, 0, 1'b0);
    do_cmd(OP_READ, SEL_INV, SEL_X, 16'h0000, 0, 1'b0);
    check_eq("bank_x", 32'(bank[0]), 32'h0000A5A5);
    do_cmd(OP_WRITE, SEL_Y, SEL_X, 16'h5A5A, 0, 1'b0);
    do_cmd(OP_MOVE, SEL_ACC, SEL_Y, 16'h0000, 0, 1'b0);
    do_cmd(OP_READ, SEL_X, SEL_ACC, 16'h0000, 0, 1'b1);
    do_cmd(2'b11, SEL_X, SEL_X, 16'hFFFF, 0, 1'b0);
    do_cmd(OP_READ, SEL_X, SEL_INV, 16'h0000, 1, 1'b0);
    do_cmd(OP_MOVE, SEL_INV, SEL_X, 16'h0000, 0, 1'b0);
    do_cmd(OP_MOVE, SEL_X, SEL_X, 16'h0000, 0, 1'b0);
    do_cmd(OP_READ, SEL_X, SEL_Y, 16'h0000, 3, 1'b0);

    reset_mid_move();
    check_eq("bank_acc_cleared", 32'(bank[2]), 32'd0);
    do_cmd(OP_READ, SEL_X, SEL_ACC, 16'h0000, 0, 1'b0);
    do_cmd(OP_READ, SEL_X, SEL_Y, 16'h0000, 0, 1'b0);
    do_cmd(OP_WRITE, SEL_X, SEL_X, 16'h1234, 2, 1'b0);
    do_cmd(OP_READ, SEL_X, SEL_X, 16'h0000, 0, 1'b0);
    do_cmd(2'b11, SEL_INV, SEL_INV, 16'h0000, 0, 1'b0);
`ifdef GPR_SEQ_OPCOUNT_EN
    check_eq("ops_wrap", 32'(bus.ops_done), 32'd1);
`endif

    for (int i = 0; i < 150; i++) begin
      r   = int'($urandom_range(0, 9));
      op  = (r < 3) ? OP_WRITE : (r < 6) ? OP_READ : (r < 9) ? OP_MOVE : 2'b11;
      r   = int'($urandom_range(0, 9));
      dst = (r == 9) ? SEL_INV : 2'($urandom_range(0, 2));
      r   = int'($urandom_range(0, 9));
      src = (r == 9) ? SEL_INV : 2'($urandom_range(0, 2));
      dly = int'($urandom_range(0, 3));
      do_cmd(op, dst, src, DATA_W'($urandom), dly, (dly == 0) && ($urandom_range(0, 1) == 1));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
